// File: rtl/key_sw_io_device_if.sv
// key_sw_io_device_if: data-memory bus between the memory stage (master) and key_sw_io_device (slave).
interface key_sw_io_device_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] memaddr;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic re;
  logic we;
  logic hit;
  modport master(output memaddr, re, we, wdata, input hit, rdata);
  modport slave(input memaddr, re, we, wdata, output hit, rdata);
endinterface

// File: rtl/key_sw_io_device.sv
// key_sw_io_device: synchronized, debounced KEY/SW data registers with sticky ready/overrun status.
// Define KEY_SW_IRQ_EN to enable the IE bits and the registered irq output.
module key_sw_io_device #(
  parameter int DBITS = 32,
  parameter logic [DBITS-1:0] ADDRKDATA = DBITS'(32'hFFFFF080),
  parameter logic [DBITS-1:0] ADDRKCTRL = DBITS'(32'hFFFFF084),
  parameter logic [DBITS-1:0] ADDRSDATA = DBITS'(32'hFFFFF090),
  parameter logic [DBITS-1:0] ADDRSCTRL = DBITS'(32'hFFFFF094),
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  key_sw_io_device_if.slave bus,
  output logic irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] k1, k2, kp, kst;
  logic [9:0] s1, s2, sp, sst;
  logic [CW-1:0] kcnt, scnt;
  logic kr, ko, sr, so, kie, sie;
  logic kd, kc, sd, sc, kdread, sdread, kcwr, scwr, kcommit, scommit;
  logic unused_wdata;
  assign kd = bus.memaddr == ADDRKDATA;
  assign kc = bus.memaddr == ADDRKCTRL;
  assign sd = bus.memaddr == ADDRSDATA;
  assign sc = bus.memaddr == ADDRSCTRL;
  assign kdread = bus.re & kd;
  assign sdread = bus.re & sd;
  assign kcwr = bus.we & kc;
  assign scwr = bus.we & sc;
  // a commit fires on the edge the stable-run counter would reach DEBOUNCE_CYCLES
  assign kcommit = (k2 == kp) && (k2 != kst) && (kcnt == LAST);
  assign scommit = (s2 == sp) && (s2 != sst) && (scnt == LAST);
  assign bus.hit = kd | kc | sd | sc;
  assign bus.rdata = kd ? DBITS'(kst) :
                     kc ? DBITS'({kie, 1'b0, ko, 1'b0, kr}) :
                     sd ? DBITS'(sst) :
                     sc ? DBITS'({sie, 1'b0, so, 1'b0, sr}) : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k1 <= '0;
      k2 <= '0;
      kp <= '0;
      kst <= '0;
      s1 <= '0;
      s2 <= '0;
      sp <= '0;
      sst <= '0;
      kcnt <= '0;
      scnt <= '0;
      kr <= 1'b0;
      ko <= 1'b0;
      sr <= 1'b0;
      so <= 1'b0;
    end else begin
      k1 <= ~KEY;
      k2 <= k1;
      kp <= k2;
      s1 <= SW;
      s2 <= s1;
      sp <= s2;
      kcnt <= (k2 != kp || k2 == kst || kcommit) ? '0 : kcnt + 1'b1;
      scnt <= (s2 != sp || s2 == sst || scommit) ? '0 : scnt + 1'b1;
      kst <= kcommit ? k2 : kst;
      sst <= scommit ? s2 : sst;
      kr <= kcommit | (kr & ~kdread);
      sr <= scommit | (sr & ~sdread);
      ko <= (kcommit & kr & ~kdread) | (ko & ~(kcwr & ~bus.wdata[2]));
      so <= (scommit & sr & ~sdread) | (so & ~(scwr & ~bus.wdata[2]));
    end
  end
`ifdef KEY_SW_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kie <= 1'b0;
      sie <= 1'b0;
      irq <= 1'b0;
    end else begin
      kie <= kcwr ? bus.wdata[4] : kie;
      sie <= scwr ? bus.wdata[4] : sie;
      irq <= (kr & kie) | (sr & sie);
    end
  end
  assign unused_wdata = ^{bus.wdata[DBITS-1:5], bus.wdata[3], bus.wdata[1:0]};
`else
  assign kie = 1'b0;
  assign sie = 1'b0;
  assign irq = 1'b0;
  assign unused_wdata = ^{bus.wdata[DBITS-1:3], bus.wdata[1:0]};
`endif
endmodule
